// File: rtl/key_led_array_if.sv
// Key/LED channel bundle: raw buttons and LED modes into the front end,
// debounced levels, strobes and LED drive back out.
interface key_led_array_if #(
    parameter int N_KEYS = 4
);
    logic [N_KEYS-1:0]   key_in;
    logic [2*N_KEYS-1:0] mode;
    logic [N_KEYS-1:0]   led;
    logic [N_KEYS-1:0]   key_state;
    logic [N_KEYS-1:0]   press_pulse;
    logic [N_KEYS-1:0]   long_pulse;

    // Board / controller side: drives keys and modes, observes results
    modport master (
        output key_in,
        output mode,
        input  led,
        input  key_state,
        input  press_pulse,
        input  long_pulse
    );

    // Front-end side
    modport slave (
        input  key_in,
        input  mode,
        output led,
        output key_state,
        output press_pulse,
        output long_pulse
    );
endinterface

// File: rtl/key_led_array.sv
// N-channel push-button front end: per key a 2-flop synchroniser,
// no-partial-credit debounce, press/release edge strobes, saturating
// long-press detector and an LED driver with selectable behaviour.
module key_led_array #(
    parameter int N_KEYS         = 4,
    parameter int DEB_CYCLES     = 1000000,
    parameter int LONG_CYCLES    = 50000000,
    parameter bit KEY_ACTIVE_LOW = 1'b1
) (
    input  logic          clk,
    input  logic          rstn,
    key_led_array_if.slave bus
);
    localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
    // Raw input level of a key that is not pressed
    localparam logic REL_LVL = KEY_ACTIVE_LOW;

    localparam logic [1:0] MODE_TOGGLE = 2'b00;
    localparam logic [1:0] MODE_FOLLOW = 2'b01;
    localparam logic [1:0] MODE_SHORT  = 2'b10;

    logic [N_KEYS-1:0] led_vec;
    logic [N_KEYS-1:0] key_state_vec;
    logic [N_KEYS-1:0] press_vec;
    logic [N_KEYS-1:0] long_vec;

    for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_ch
        logic              sync1_q, sync2_q;
        logic              pressed;
        logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
        logic              key_state_q, key_state_d;
        logic              key_prev_q;
        logic              press_q, rel_q;
        logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
        logic              long_q, long_d;
        logic              long_seen_q, long_seen_d;
        logic              led_q, led_d;
        logic [1:0]        ch_mode;

        assign pressed = sync2_q ^ REL_LVL;
        assign ch_mode = bus.mode[2*gi +: 2];

        // Debounce: count while the level disagrees, accept on the last count
        always_comb begin
            deb_cnt_d   = deb_cnt_q;
            key_state_d = key_state_q;
            if (pressed == key_state_q) begin
                deb_cnt_d = '0;
            end else if (deb_cnt_q == DEB_LAST) begin
                key_state_d = pressed;
                deb_cnt_d   = '0;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end

        // Hold timer saturates at LONG_CYCLES so the long strobe fires once per press
        always_comb begin
            hold_cnt_d = hold_cnt_q;
            if (!key_state_q) begin
                hold_cnt_d = '0;
            end else if (hold_cnt_q != HOLD_MAX) begin
                hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
            long_d = key_state_q && (hold_cnt_q == HOLD_LAST);
        end

        // LED next state from the strobes under the channel's current mode
        always_comb begin
            long_seen_d = long_seen_q;
            if (press_q) begin
                long_seen_d = 1'b0;
            end else if (long_q) begin
                long_seen_d = 1'b1;
            end

            led_d = led_q;
            case (ch_mode)
                MODE_FOLLOW: led_d = key_state_q;
                MODE_SHORT: begin
                    if (long_q) begin
                        led_d = 1'b0;
                    end else if (rel_q && !long_seen_q) begin
                        led_d = ~led_q;
                    end
                end
                default: begin
                    if (press_q) begin
                        led_d = ~led_q;
                    end
                end
            endcase
        end

        // Channel state registers; synchroniser resets to the released level
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                sync1_q     <= REL_LVL;
                sync2_q     <= REL_LVL;
                deb_cnt_q   <= '0;
                key_state_q <= 1'b0;
                key_prev_q  <= 1'b0;
                press_q     <= 1'b0;
                rel_q       <= 1'b0;
                hold_cnt_q  <= '0;
                long_q      <= 1'b0;
                long_seen_q <= 1'b0;
                led_q       <= 1'b0;
            end else begin
                sync1_q     <= bus.key_in[gi];
                sync2_q     <= sync1_q;
                deb_cnt_q   <= deb_cnt_d;
                key_state_q <= key_state_d;
                key_prev_q  <= key_state_q;
                press_q     <= key_state_q & ~key_prev_q;
                rel_q       <= ~key_state_q & key_prev_q;
                hold_cnt_q  <= hold_cnt_d;
                long_q      <= long_d;
                long_seen_q <= long_seen_d;
                led_q       <= led_d;
            end
        end

        assign led_vec[gi]       = led_q;
        assign key_state_vec[gi] = key_state_q;
        assign press_vec[gi]     = press_q;
        assign long_vec[gi]      = long_q;
    end

    assign bus.led         = led_vec;
    assign bus.key_state   = key_state_vec;
    assign bus.press_pulse = press_vec;
    assign bus.long_pulse  = long_vec;
endmodule

// File: tb/tb_key_led_array.sv
// Scoreboard bench for key_led_array: DUT A (active-low keys) on channels
// 0..3 and DUT B (active-high keys) on channels 4..7 of a combined view.
// Stimulus pushes expected events; the monitor pops one whenever a strobe
// fires or key_state changes, and checks led two cycles after each event.
module tb_key_led_array;
    logic clk;
    logic rstn;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    key_led_array_if #(.N_KEYS(4)) if_a ();
    key_led_array_if #(.N_KEYS(4)) if_b ();

    key_led_array #(
        .N_KEYS(4), .DEB_CYCLES(4), .LONG_CYCLES(20), .KEY_ACTIVE_LOW(1'b1)
    ) dut_a (
        .clk(clk), .rstn(rstn), .bus(if_a)
    );

    key_led_array #(
        .N_KEYS(4), .DEB_CYCLES(4), .LONG_CYCLES(20), .KEY_ACTIVE_LOW(1'b0)
    ) dut_b (
        .clk(clk), .rstn(rstn), .bus(if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index = number of rising edges seen so far
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] press_all, long_all, ks_all, led_all;
    assign press_all = {if_b.press_pulse, if_a.press_pulse};
    assign long_all  = {if_b.long_pulse,  if_a.long_pulse};
    assign ks_all    = {if_b.key_state,   if_a.key_state};
    assign led_all   = {if_b.led,         if_a.led};

    typedef struct {
        int         cyc;
        logic [7:0] p;
        logic [7:0] l;
        logic [7:0] k;
        logic [7:0] led;
    } ev_t;

    typedef struct {
        int         cyc;
        logic [7:0] led;
    } ledchk_t;

    ev_t     exp_q[$];
    ledchk_t led_chk_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic [7:0] p, input logic [7:0] l,
                        input logic [7:0] k, input logic [7:0] ld);
        ev_t e;
        e.cyc = c; e.p = p; e.l = l; e.k = k; e.led = ld;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic hold_a(input int ch, input int len);
        int t0;
        t0 = cyc;
        if_a.key_in[ch] = 1'b0;
        wait_cyc(t0 + len);
        if_a.key_in[ch] = 1'b1;
    endtask

    // Monitor: compare every observed event against the scoreboard
    initial begin : monitor
        logic [7:0] ks_prev;
        ev_t        e;
        ledchk_t    lc;
        ks_prev = 8'h00;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                led_chk_q.delete();
                ks_prev = ks_all;
            end else begin
                while (led_chk_q.size() > 0 && led_chk_q[0].cyc <= cyc) begin
                    lc = led_chk_q.pop_front();
                    chk("led_after_event", {24'h0, led_all}, {24'h0, lc.led});
                end
                if (press_all != 8'h00 || long_all != 8'h00 || ks_all != ks_prev) begin
                    $display("event cyc=%0d press=%02h long=%02h key_state=%02h led=%02h",
                             cyc, press_all, long_all, ks_all, led_all);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_event actual press=%02h long=%02h ks=%02h required none",
                                 press_all, long_all, ks_all);
                    end else begin
                        e = exp_q.pop_front();
                        chk("event_cycle", cyc, e.cyc);
                        chk("press_pulse", {24'h0, press_all}, {24'h0, e.p});
                        chk("long_pulse",  {24'h0, long_all},  {24'h0, e.l});
                        chk("key_state",   {24'h0, ks_all},    {24'h0, e.k});
                        lc.cyc = e.cyc + 2;
                        lc.led = e.led;
                        led_chk_q.push_back(lc);
                    end
                end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                    e = exp_q.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL missing_event actual none required at cyc %0d ks=%02h", e.cyc, e.k);
                end
                ks_prev = ks_all;
            end
        end
    end

    initial begin : watchdog
        repeat (3000) @(posedge clk);
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int n, n2, n3, r;
        int dur [5];
        logic lvl [5];
        dur = '{3, 1, 3, 1, 8};
        lvl = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        rstn = 1'b0;
        if_a.key_in = 4'hF;
        if_a.mode   = 8'h00;
        if_b.key_in = 4'h0;
        if_b.mode   = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_led",   {24'h0, led_all},   32'h0);
        chk("reset_ks",    {24'h0, ks_all},    32'h0);
        chk("reset_press", {24'h0, press_all}, 32'h0);
        chk("reset_long",  {24'h0, long_all},  32'h0);
        rstn = 1'b1;
        wait_cyc(cyc + 10);

        // Toggle mode, ch0: two identical presses
        n = cyc;
        push(n + 6,  8'h00, 8'h00, 8'h01, 8'h01);
        push(n + 7,  8'h01, 8'h00, 8'h01, 8'h01);
        push(n + 16, 8'h00, 8'h00, 8'h00, 8'h01);
        hold_a(0, 10);
        wait_cyc(n + 20);
        n = cyc;
        push(n + 6,  8'h00, 8'h00, 8'h01, 8'h00);
        push(n + 7,  8'h01, 8'h00, 8'h01, 8'h00);
        push(n + 16, 8'h00, 8'h00, 8'h00, 8'h00);
        hold_a(0, 10);
        wait_cyc(n + 20);

        // Bounce on ch1: only the final 8-clock low run is accepted
        n = cyc;
        push(n + 14, 8'h00, 8'h00, 8'h02, 8'h02);
        push(n + 15, 8'h02, 8'h00, 8'h02, 8'h02);
        push(n + 22, 8'h00, 8'h00, 8'h00, 8'h02);
        for (int i = 0; i < 5; i++) begin
            if_a.key_in[1] = lvl[i];
            repeat (dur[i]) @(negedge clk);
        end
        if_a.key_in[1] = 1'b1;
        wait_cyc(n + 26);

        // Short/long mode on ch2
        if_a.mode = 8'h20;
        n = cyc;
        push(n + 6,  8'h00, 8'h00, 8'h04, 8'h02);
        push(n + 7,  8'h04, 8'h00, 8'h04, 8'h02);
        push(n + 14, 8'h00, 8'h00, 8'h00, 8'h06);
        hold_a(2, 8);
        wait_cyc(n + 18);
        n2 = cyc;
        push(n2 + 6,  8'h00, 8'h00, 8'h04, 8'h06);
        push(n2 + 7,  8'h04, 8'h00, 8'h04, 8'h06);
        push(n2 + 26, 8'h00, 8'h04, 8'h04, 8'h02);
        push(n2 + 36, 8'h00, 8'h00, 8'h00, 8'h02);
        hold_a(2, 30);
        wait_cyc(n2 + 40);
        n3 = cyc;
        push(n3 + 6,  8'h00, 8'h00, 8'h04, 8'h02);
        push(n3 + 7,  8'h04, 8'h00, 8'h04, 8'h02);
        push(n3 + 14, 8'h00, 8'h00, 8'h00, 8'h06);
        hold_a(2, 8);
        wait_cyc(n3 + 18);

        // Follow on ch3 and toggle on ch0, pressed in the same cycle
        if_a.mode = 8'h60;
        n = cyc;
        push(n + 6,  8'h00, 8'h00, 8'h09, 8'h0F);
        push(n + 7,  8'h09, 8'h00, 8'h09, 8'h0F);
        push(n + 16, 8'h00, 8'h00, 8'h00, 8'h07);
        if_a.key_in = 4'b0110;
        wait_cyc(n + 6);
        chk("follow_lag_off", {31'h0, if_a.led[3]}, 32'h0);
        wait_cyc(n + 7);
        chk("follow_lag_on",  {31'h0, if_a.led[3]}, 32'h1);
        wait_cyc(n + 10);
        if_a.key_in = 4'hF;
        wait_cyc(n + 16);
        chk("follow_hold_on", {31'h0, if_a.led[3]}, 32'h1);
        wait_cyc(n + 17);
        chk("follow_clear",   {31'h0, if_a.led[3]}, 32'h0);
        wait_cyc(n + 20);

        // Reset in the middle of a ch2 press, key held through reset
        n = cyc;
        push(n + 6, 8'h00, 8'h00, 8'h04, 8'h07);
        push(n + 7, 8'h04, 8'h00, 8'h04, 8'h07);
        if_a.key_in[2] = 1'b0;
        wait_cyc(n + 10);
        rstn = 1'b0;
        #1;
        chk("midrst_led",   {24'h0, led_all},   32'h0);
        chk("midrst_ks",    {24'h0, ks_all},    32'h0);
        chk("midrst_press", {24'h0, press_all}, 32'h0);
        chk("midrst_long",  {24'h0, long_all},  32'h0);
        wait_cyc(n + 13);
        r = cyc;
        push(r + 6,  8'h00, 8'h00, 8'h04, 8'h00);
        push(r + 7,  8'h04, 8'h00, 8'h04, 8'h00);
        push(r + 26, 8'h00, 8'h04, 8'h04, 8'h00);
        push(r + 36, 8'h00, 8'h00, 8'h00, 8'h00);
        rstn = 1'b1;
        wait_cyc(r + 30);
        if_a.key_in[2] = 1'b1;
        wait_cyc(r + 45);

        // Active-high DUT: 6-clock high pulse on its ch0 (combined bit 4)
        n = cyc;
        push(n + 6,  8'h00, 8'h00, 8'h10, 8'h10);
        push(n + 7,  8'h10, 8'h00, 8'h10, 8'h10);
        push(n + 12, 8'h00, 8'h00, 8'h00, 8'h10);
        if_b.key_in[0] = 1'b1;
        wait_cyc(n + 6);
        if_b.key_in[0] = 1'b0;
        wait_cyc(n + 20);

        // Idle-high keys on the active-low DUT must stay silent
        wait_cyc(cyc + 30);
        chk("pending_events", exp_q.size(), 32'h0);
        chk("pending_led_checks", led_chk_q.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
